// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings (OP_MUL, OP_MULH, OP_DIV, OP_REM)
//   - FSM state enum (S_IDLE, S_RUN, S_FIX, S_DONE)
package multdiv_pkg;

  localparam logic [1:0] OP_MUL  = 2'b00;  // low half of product
  localparam logic [1:0] OP_MULH = 2'b01;  // high half of product
  localparam logic [1:0] OP_DIV  = 2'b10;  // quotient
  localparam logic [1:0] OP_REM  = 2'b11;  // remainder

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/multdiv_if.sv
// multdiv_if: request/response bundle between the execute stage and the
// multiply/divide unit.
//   master (pipeline): drives start, op, is_signed, operand_a, operand_b;
//                      observes busy, result, exception, result_rdy.
//   slave  (unit)    : the reverse.
interface multdiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic             is_signed;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             exception;
  logic             result_rdy;

  modport master (
    output start, op, is_signed, operand_a, operand_b,
    input  busy, result, exception, result_rdy
  );

  modport slave (
    input  start, op, is_signed, operand_a, operand_b,
    output busy, result, exception, result_rdy
  );
endinterface

// File: rtl/cond_negate.sv
// cond_negate: passes i_x through, or its two's-complement negation
// (~x + 1 at WIDTH bits) when i_en is high. Purely combinational.
//   i_en : negate enable
//   i_x  : input value
//   o_y  : i_x or -i_x
module cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_x,
  output logic [WIDTH-1:0] o_y
);
  assign o_y = i_en ? (~i_x + WIDTH'(1)) : i_x;
endmodule

// File: rtl/multdiv_iter.sv
// multdiv_iter: iterative radix-2 multiply/divide unit with fixed latency.
// Operands are reduced to magnitudes on start, a WIDTH-step unsigned
// shift-add (MUL/MULH) or restoring shift-subtract (DIV/REM) runs, then a
// fix-up cycle restores signs and applies special-case results.
// result_rdy pulses WIDTH+2 cycles after start.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : multdiv_if slave (start/op/is_signed/operands in,
//             busy/result/exception/result_rdy out)
module multdiv_iter
  import multdiv_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic     clock,
  input  logic     reset_n,
  multdiv_if.slave bus
);

  localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             r_state;
  logic [CW-1:0]      r_cnt;
  logic [1:0]         r_op;
  logic               r_signed;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [WIDTH-1:0]   r_a_raw;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mag_b;
  // MUL: {carry, hi, lo}; DIV: {rem (WIDTH+1), quot (WIDTH)}
  logic [2*WIDTH:0]   r_acc;
  logic               r_busy;
  logic               r_rdy;
  logic               r_exc;
  logic [WIDTH-1:0]   r_result;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH:0]   w_mul_next;
  logic [2*WIDTH:0]   w_div_sh;
  logic [WIDTH:0]     w_div_trial;
  logic [2*WIDTH:0]   w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic               w_b_zero;
  logic               w_div_ovf;
  logic [WIDTH-1:0]   w_fix_result;
  logic               w_fix_exc;

  // Operand magnitudes; MIN_INT maps onto unsigned 2^(WIDTH-1).
  cond_negate #(.WIDTH(WIDTH)) u_neg_a (
    .i_en (bus.is_signed & bus.operand_a[WIDTH-1]),
    .i_x  (bus.operand_a),
    .o_y  (w_mag_a)
  );
  cond_negate #(.WIDTH(WIDTH)) u_neg_b (
    .i_en (bus.is_signed & bus.operand_b[WIDTH-1]),
    .i_x  (bus.operand_b),
    .o_y  (w_mag_b)
  );

  // Shift-add step: add multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole register right.
  assign w_mul_sum  = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_mag_a} : '0);
  assign w_mul_next = {1'b0, w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring step: shift left, trial-subtract divisor; bit WIDTH of the
  // trial result is its sign, so a clear bit means the subtract fits.
  assign w_div_sh    = {r_acc[2*WIDTH-1:0], 1'b0};
  assign w_div_trial = w_div_sh[2*WIDTH:WIDTH] - {1'b0, r_mag_b};
  assign w_div_next  = w_div_trial[WIDTH] ? w_div_sh
                                          : {w_div_trial, w_div_sh[WIDTH-1:1], 1'b1};

  // Sign restoration for the fix-up cycle.
  cond_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
    .i_en (r_sign_a ^ r_sign_b),
    .i_x  (r_acc[2*WIDTH-1:0]),
    .o_y  (w_prod)
  );
  cond_negate #(.WIDTH(WIDTH)) u_neg_quot (
    .i_en (r_sign_a ^ r_sign_b),
    .i_x  (r_acc[WIDTH-1:0]),
    .o_y  (w_quot)
  );
  cond_negate #(.WIDTH(WIDTH)) u_neg_rem (
    .i_en (r_sign_a),
    .i_x  (r_acc[2*WIDTH-1:WIDTH]),
    .o_y  (w_rem)
  );

  assign w_b_zero  = (r_mag_b == '0);
  assign w_div_ovf = r_signed & r_sign_a & r_sign_b &
                     (r_mag_a == MIN_MAG) & (r_mag_b == WIDTH'(1));

  always_comb begin
    w_fix_result = '0;
    w_fix_exc    = 1'b0;
    case (r_op)
      OP_MUL: begin
        w_fix_result = w_prod[WIDTH-1:0];
        if (r_signed)
          w_fix_exc = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});
        else
          w_fix_exc = (w_prod[2*WIDTH-1:WIDTH] != '0);
      end
      OP_MULH: w_fix_result = w_prod[2*WIDTH-1:WIDTH];
      OP_DIV: begin
        if (w_b_zero) begin
          w_fix_result = '1;
          w_fix_exc    = 1'b1;
        end else if (w_div_ovf) begin
          w_fix_result = MIN_MAG;
          w_fix_exc    = 1'b1;
        end else begin
          w_fix_result = w_quot;
        end
      end
      default: begin  // OP_REM
        if (w_b_zero) begin
          w_fix_result = r_a_raw;
          w_fix_exc    = 1'b1;
        end else if (w_div_ovf) begin
          w_fix_result = '0;
          w_fix_exc    = 1'b1;
        end else begin
          w_fix_result = w_rem;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= OP_MUL;
      r_signed <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_a_raw  <= '0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_rdy    <= 1'b0;
      r_exc    <= 1'b0;
      r_result <= '0;
    end else begin
      r_rdy <= 1'b0;
      // start in any state (re)starts; an op still in RUN/FIX is dropped.
      if (bus.start) begin
        r_state  <= S_RUN;
        r_cnt    <= '0;
        r_op     <= bus.op;
        r_signed <= bus.is_signed;
        r_sign_a <= bus.is_signed & bus.operand_a[WIDTH-1];
        r_sign_b <= bus.is_signed & bus.operand_b[WIDTH-1];
        r_a_raw  <= bus.operand_a;
        r_mag_a  <= w_mag_a;
        r_mag_b  <= w_mag_b;
        r_acc    <= bus.op[1] ? {{(WIDTH+1){1'b0}}, w_mag_a}
                              : {{(WIDTH+1){1'b0}}, w_mag_b};
        r_busy   <= 1'b1;
      end else begin
        case (r_state)
          S_RUN: begin
            r_acc <= r_op[1] ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(WIDTH - 1))
              r_state <= S_FIX;
          end
          S_FIX: begin
            r_result <= w_fix_result;
            r_exc    <= w_fix_exc;
            r_rdy    <= 1'b1;
            r_state  <= S_DONE;
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy       = r_busy;
  assign bus.result     = r_result;
  assign bus.exception  = r_exc;
  assign bus.result_rdy = r_rdy;

endmodule

// File: tb/tb_multdiv_iter.sv
// tb_multdiv_iter: scoreboard bench for multdiv_iter (WIDTH=32 and WIDTH=8).
// Stimulus pushes expected result/exception/cycle into per-instance queues;
// monitors pop and compare on every result_rdy.
module tb_multdiv_iter;
  import multdiv_pkg::*;

  typedef struct {
    logic [63:0] res;
    logic        exc;
    int          cyc;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t q32[$];
  exp_t q8[$];

  multdiv_if #(.WIDTH(32)) bus32 ();
  multdiv_if #(.WIDTH(8))  bus8 ();

  multdiv_iter #(.WIDTH(32)) u_dut32 (.clock(clk), .reset_n(reset_n), .bus(bus32));
  multdiv_iter #(.WIDTH(8))  u_dut8  (.clock(clk), .reset_n(reset_n), .bus(bus8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Called #1 after a rising edge; start is high for exactly that cycle.
  task automatic issue32(input logic [1:0] op, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic push, input logic [31:0] res,
                         input logic exc, input string name);
    exp_t e;
    bus32.start = 1'b1; bus32.op = op; bus32.is_signed = sgn;
    bus32.operand_a = a; bus32.operand_b = b;
    if (push) begin
      e.res = {32'b0, res}; e.exc = exc; e.cyc = cyc + 34; e.name = name;
      q32.push_back(e);
    end
    @(posedge clk); #1;
    bus32.start = 1'b0;
  endtask

  task automatic issue8(input logic [1:0] op, input logic sgn, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] res, input logic exc,
                        input string name);
    exp_t e;
    bus8.start = 1'b1; bus8.op = op; bus8.is_signed = sgn;
    bus8.operand_a = a; bus8.operand_b = b;
    e.res = {56'b0, res}; e.exc = exc; e.cyc = cyc + 10; e.name = name;
    q8.push_back(e);
    @(posedge clk); #1;
    bus8.start = 1'b0;
  endtask

  task automatic run32(input logic [1:0] op, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic exc,
                       input string name);
    issue32(op, sgn, a, b, 1'b1, res, exc, name);
    repeat (36) begin @(posedge clk); #1; end
  endtask

  // Monitors
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus32.result_rdy) begin
        if (q32.size() == 0) begin
          check("rdy32_unexpected", 64'd1, 64'd0);
        end else begin
          e = q32.pop_front();
          $display("txn32 %s result=%h exc=%0b cycle=%0d", e.name, bus32.result,
                   bus32.exception, cyc);
          check({e.name, "_res"}, {32'b0, bus32.result}, e.res);
          check({e.name, "_exc"}, {63'b0, bus32.exception}, {63'b0, e.exc});
          check({e.name, "_cyc"}, 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus8.result_rdy) begin
        if (q8.size() == 0) begin
          check("rdy8_unexpected", 64'd1, 64'd0);
        end else begin
          e = q8.pop_front();
          $display("txn8 %s result=%h exc=%0b cycle=%0d", e.name, bus8.result,
                   bus8.exception, cyc);
          check({e.name, "_res"}, {56'b0, bus8.result}, e.res);
          check({e.name, "_exc"}, {63'b0, bus8.exception}, {63'b0, e.exc});
          check({e.name, "_cyc"}, 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin
    bus32.start = 1'b0; bus32.op = OP_MUL; bus32.is_signed = 1'b0;
    bus32.operand_a = '0; bus32.operand_b = '0;
    bus8.start = 1'b0; bus8.op = OP_MUL; bus8.is_signed = 1'b0;
    bus8.operand_a = '0; bus8.operand_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'b0, bus32.busy}, 64'd0);
    check("rst_rdy", {63'b0, bus32.result_rdy}, 64'd0);
    check("rst_result", {32'b0, bus32.result}, 64'd0);
    check("rst_exc", {63'b0, bus32.exception}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // MUL signed -7*6 with busy window checks (start = cycle 0)
    issue32(OP_MUL, 1'b1, 32'hFFFFFFF9, 32'd6, 1'b1, 32'hFFFFFFD6, 1'b0, "mul_s");
    check("busy_c1", {63'b0, bus32.busy}, 64'd1);
    repeat (33) begin @(posedge clk); #1; end
    check("busy_c34", {63'b0, bus32.busy}, 64'd1);
    @(posedge clk); #1;
    check("busy_c35", {63'b0, bus32.busy}, 64'd0);
    repeat (2) begin @(posedge clk); #1; end

    run32(OP_MULH, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "mulh_u");
    run32(OP_MUL,  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1, "mul_u_ovf");
    run32(OP_MULH, 1'b1, 32'hFFFFFFF9, 32'd6,        32'hFFFFFFFF, 1'b0, "mulh_s");
    run32(OP_MUL,  1'b1, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, "mul_s_ovf");
    run32(OP_DIV,  1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, "div_s");
    run32(OP_REM,  1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, "rem_s");
    run32(OP_DIV,  1'b0, 32'd100,      32'd0,        32'hFFFFFFFF, 1'b1, "div_by0");
    run32(OP_REM,  1'b0, 32'd100,      32'd0,        32'd100,      1'b1, "rem_by0");
    run32(OP_DIV,  1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "div_ovf");
    run32(OP_REM,  1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, "rem_ovf");
    run32(OP_DIV,  1'b0, 32'd100,      32'd7,        32'd14,       1'b0, "div_u");

    // Restart: DIV aborted by MUL at cycle 10; only the MUL completes (cycle 44)
    issue32(OP_DIV, 1'b0, 32'd100, 32'd7, 1'b0, 32'd0, 1'b0, "div_abort");
    repeat (9) begin @(posedge clk); #1; end
    run32(OP_MUL, 1'b0, 32'd3, 32'd5, 32'd15, 1'b0, "mul_restart");

    // Start in DONE cycle: old result still pulses, new op follows
    issue32(OP_MUL, 1'b0, 32'd9, 32'd9, 1'b1, 32'd81, 1'b0, "mul_done_old");
    repeat (33) begin @(posedge clk); #1; end
    run32(OP_DIV, 1'b0, 32'd81, 32'd4, 32'd20, 1'b0, "div_done_new");

    // Reset at cycle 20 of an op: outputs drop at once, no pulse follows
    issue32(OP_DIV, 1'b0, 32'd1000, 32'd3, 1'b0, 32'd0, 1'b0, "div_reset");
    repeat (19) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    check("rstmid_busy", {63'b0, bus32.busy}, 64'd0);
    check("rstmid_rdy", {63'b0, bus32.result_rdy}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; end

    // WIDTH=8 instance
    issue8(OP_DIV, 1'b1, 8'h80, 8'd3, 8'hD6, 1'b0, "w8_div_s");
    repeat (12) begin @(posedge clk); #1; end
    issue8(OP_REM, 1'b1, 8'h80, 8'd3, 8'hFE, 1'b0, "w8_rem_s");
    repeat (12) begin @(posedge clk); #1; end

    check("q32_drained", 64'(q32.size()), 64'd0);
    check("q8_drained", 64'(q8.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
